// File: rtl/fetch_stage_pkg.sv
// Shared fetch-pipeline types and constants: NOP encoding, default reset PC
// and the {pc, instr, misalign} entry carried through the prefetch buffer.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop, flush and occupancy.
// A push in the same cycle as a flush survives the flush.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_din,
  output fetch_entry_t           o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_push = i_push & (i_flush | ~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_count  <= (AW+1)'(w_push);
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, credit-limited imem requests,
// in-order prefetch buffer and wrong-path drop. Option: FETCH_MISALIGN_CHECK_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCP4F,
  output logic        InstrValidF
`ifdef FETCH_MISALIGN_CHECK_EN
  , output logic      InstrMisalignF
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]  r_pc_q;
  logic [CW-1:0] r_out_q;
  logic [CW-1:0] r_drop_q;

  fetch_entry_t w_head;
  fetch_entry_t w_tag_head;
  fetch_entry_t w_tag_din;
  fetch_entry_t w_buf_din;
  logic          w_empty, w_full, w_tag_full, w_tag_empty;
  logic [CW-1:0] w_occ, w_tag_cnt, w_occ_eff;
  logic [CW:0]   w_used;
  logic          w_pop, w_req_fire, w_rsp_keep, w_req_mis;
  logic [31:0]   w_target;
  logic          w_unused;

  // Low address bits are never fetched; a misaligned target is only tagged.
  assign w_target = {PCTargetE[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_mis_pend;
  logic w_target_mis;
  assign w_target_mis = |PCTargetE[1:0];
  assign w_req_mis    = PCSrcE ? w_target_mis : r_mis_pend;

  always_ff @(posedge clk) begin
    if (rst)             r_mis_pend <= 1'b0;
    else if (w_req_fire) r_mis_pend <= 1'b0;
    else if (PCSrcE)     r_mis_pend <= w_target_mis;
  end

  assign InstrMisalignF = InstrValidF & w_head.misalign;
  assign w_unused = ^{w_tag_head.instr, w_tag_cnt, w_tag_full, w_tag_empty, w_full};
`else
  assign w_req_mis = 1'b0;
  assign w_unused  = ^{w_tag_head.instr, w_tag_cnt, w_tag_full, w_tag_empty, w_full,
                       PCTargetE[1:0], w_head.misalign};
`endif

  assign InstrValidF = ~w_empty;
  assign w_pop       = InstrValidF & ~StallF & ~PCSrcE;

  // A redirect flushes the buffer this cycle, so its entries free their credit now.
  assign w_occ_eff      = PCSrcE ? '0 : w_occ;
  assign w_used         = {1'b0, r_out_q} + {1'b0, w_occ_eff} - (CW+1)'(w_pop);
  assign imem_req_valid = ~rst & (w_used < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = PCSrcE ? w_target : r_pc_q;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_rsp_keep = imem_rsp_valid & (r_drop_q == '0) & ~PCSrcE;

  assign w_tag_din = '{pc: imem_req_addr, instr: 32'd0, misalign: w_req_mis};
  assign w_buf_din = '{pc: w_tag_head.pc, instr: imem_rsp_data, misalign: w_tag_head.misalign};

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_req_fire),
    .i_pop   (w_rsp_keep),
    .i_flush (PCSrcE),
    .i_din   (w_tag_din),
    .o_dout  (w_tag_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_cnt)
  );

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rsp_keep),
    .i_pop   (w_pop),
    .i_flush (PCSrcE),
    .i_din   (w_buf_din),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_occ)
  );

  // drop_q counts old-path requests still in flight; the redirect-cycle response is already gone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_q   <= RESET_PC;
      r_out_q  <= '0;
      r_drop_q <= '0;
    end else begin
      if (w_req_fire)  r_pc_q <= pc_plus4(imem_req_addr);
      else if (PCSrcE) r_pc_q <= w_target;
      r_out_q <= r_out_q + CW'(w_req_fire) - CW'(imem_rsp_valid);
      if (PCSrcE)
        r_drop_q <= r_out_q - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && (r_drop_q != '0))
        r_drop_q <= r_drop_q - CW'(1);
    end
  end

  assign InstrF = InstrValidF ? w_head.instr : NOP_INSTR;
  assign PCF    = InstrValidF ? w_head.pc    : r_pc_q;
  assign PCP4F  = pc_plus4(PCF);

endmodule
